ad7606_emu: RTL and testbench

AD7606_EMU -- requirements
Module: ad7606_emu

---
 rtl/ad7606_emu.sv | 152 +++++++++++++++
 tb/tb_ad7606_emu.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/ad7606_emu.sv
// AD7606 emulator: responds to CONVST/CS/RD like the real ADC so the existing
// controller can be exercised in FPGA. Each sample word carries a running
// conversion count and its channel index, so the controller's data path can
// be checked end to end.
module ad7606_emu #(
    parameter int BUSY_BASE_CYC = 200,
    parameter int NUM_CH        = 8
) (
    input  logic        fpga_clk_i,
    input  logic        reset_n_i,
    input  logic        adc_convst_i,
    input  logic        adc_reset_i,
    input  logic [2:0]  adc_os_i,
    input  logic        adc_cs_n_i,
    input  logic        adc_rd_n_i,
    output logic [15:0] adc_db_o,
    output logic        adc_busy_o,
    output logic        adc_frstdata_o
);

    // Counter wide enough for the longest BUSY (oversampling code 6 = x64).
    localparam int CNT_W = $clog2(BUSY_BASE_CYC * 64 + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CONV  = 2'd1,
        READY = 2'd2
    } state_t;

    state_t             state_r;
    logic               convst_r;
    logic               rd_n_r;
    logic               convst_rise_s;
    logic               rd_fall_s;
    logic               rd_rise_s;
    logic [CNT_W-1:0]   busy_cnt_r;
    logic [CNT_W-1:0]   busy_load_s;
    logic [2:0]         ptr_r;
    logic [2:0]         ptr_next_s;
    logic [12:0]        conv_cnt_r;
    logic [15:0]        db_r;
    logic               busy_r;
    logic               frst_r;

    // BUSY length for an oversampling code; code 7 is reserved and behaves as 0.
    function automatic logic [CNT_W-1:0] busy_len_f(input logic [2:0] os);
        logic [CNT_W-1:0] base;
        base = CNT_W'(BUSY_BASE_CYC);
        case (os)
            3'd7:    busy_len_f = base;
            default: busy_len_f = base << os;
        endcase
    endfunction

    // Edge detection, busy reload value and channel pointer wrap.
    always_comb begin
        convst_rise_s = adc_convst_i & ~convst_r;
        rd_fall_s     = ~adc_rd_n_i & rd_n_r;
        rd_rise_s     = adc_rd_n_i & ~rd_n_r;
        // The count runs N-1 down to 0, giving exactly N cycles of BUSY.
        busy_load_s   = busy_len_f(adc_os_i) - {{(CNT_W-1){1'b0}}, 1'b1};
        if (ptr_r == 3'(NUM_CH - 1)) begin
            ptr_next_s = 3'd0;
        end else begin
            ptr_next_s = ptr_r + 3'd1;
        end
    end

    // Edge registers keep tracking during ADC RESET so a CONVST held high
    // across the reset is not seen as a fresh edge afterwards.
    always_ff @(posedge fpga_clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            convst_r <= 1'b0;
            rd_n_r   <= 1'b1;
        end else begin
            convst_r <= adc_convst_i;
            rd_n_r   <= adc_rd_n_i;
        end
    end

    // Conversion/readout state machine with registered bus outputs.
    always_ff @(posedge fpga_clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r    <= IDLE;
            busy_r     <= 1'b0;
            busy_cnt_r <= {CNT_W{1'b0}};
            ptr_r      <= 3'd0;
            conv_cnt_r <= 13'd0;
            db_r       <= 16'h0000;
            frst_r     <= 1'b0;
        end else if (adc_reset_i) begin
            state_r    <= IDLE;
            busy_r     <= 1'b0;
            busy_cnt_r <= {CNT_W{1'b0}};
            ptr_r      <= 3'd0;
            conv_cnt_r <= 13'd0;
            db_r       <= 16'h0000;
            frst_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (convst_rise_s) begin
                        state_r    <= CONV;
                        busy_r     <= 1'b1;
                        busy_cnt_r <= busy_load_s;
                    end
                end
                CONV: begin
                    // Further CONVST edges are ignored; the os code was
                    // captured in the count when the conversion started.
                    if (busy_cnt_r == {CNT_W{1'b0}}) begin
                        state_r    <= READY;
                        busy_r     <= 1'b0;
                        ptr_r      <= 3'd0;
                        conv_cnt_r <= conv_cnt_r + 13'd1;
                    end else begin
                        busy_cnt_r <= busy_cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                READY: begin
                    // A new conversion wins over a coincident read.
                    if (convst_rise_s) begin
                        state_r    <= CONV;
                        busy_r     <= 1'b1;
                        busy_cnt_r <= busy_load_s;
                    end else if (!adc_cs_n_i) begin
                        if (rd_fall_s) begin
                            db_r   <= {conv_cnt_r, ptr_r};
                            frst_r <= (ptr_r == 3'd0);
                        end else if (rd_rise_s) begin
                            ptr_r <= ptr_next_s;
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
            // Deselecting the chip clears the bus regardless of state.
            if (adc_cs_n_i) begin
                db_r   <= 16'h0000;
                frst_r <= 1'b0;
            end
        end
    end

    assign adc_db_o       = db_r;
    assign adc_busy_o     = busy_r;
    assign adc_frstdata_o = frst_r;

endmodule

// File: tb/tb_ad7606_emu.sv
// Bench for ad7606_emu: stimulus pushes expected BUSY lengths and read words
// into queues; a monitor on the falling clock edge pops and compares them
// whenever BUSY ends or a read strobe completes.
module tb_ad7606_emu;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        convst = 1'b0;
    logic        adc_reset = 1'b0;
    logic [2:0]  os = 3'd0;
    logic        cs_n = 1'b1;
    logic        rd_n = 1'b1;
    logic [15:0] db;
    logic        busy;
    logic        frst;

    int          busy_q[$];
    logic [16:0] rd_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          busy_run = 0;
    logic        rd_n_prev = 1'b1;
    int          chk_req = 0;
    int          chk_seen = 0;
    logic        done_req = 1'b0;

    ad7606_emu #(.BUSY_BASE_CYC(200), .NUM_CH(8)) dut (
        .fpga_clk_i     (clk),
        .reset_n_i      (reset_n),
        .adc_convst_i   (convst),
        .adc_reset_i    (adc_reset),
        .adc_os_i       (os),
        .adc_cs_n_i     (cs_n),
        .adc_rd_n_i     (rd_n),
        .adc_db_o       (db),
        .adc_busy_o     (busy),
        .adc_frstdata_o (frst)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: all comparisons happen here, away from the active edge.
    always @(negedge clk) begin
        logic [16:0] e;
        if (chk_req != chk_seen) begin
            chk_seen = chk_req;
            cmp("idle_busy", int'(busy), 0);
            cmp("idle_db", int'(db), 0);
            cmp("idle_frst", int'(frst), 0);
        end
        if (busy === 1'b1) begin
            busy_run++;
        end else if (busy_run != 0) begin
            if (busy_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL busy_len: unexpected pulse of %0d cycles, expected none", busy_run);
            end else begin
                cmp("busy_len", busy_run, busy_q.pop_front());
            end
            busy_run = 0;
        end
        if (rd_n_prev == 1'b0 && rd_n == 1'b1) begin
            if (rd_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL read: unexpected strobe, got db 0x%0h", db);
            end else begin
                e = rd_q.pop_front();
                cmp("read_word", int'({frst, db}), int'(e));
            end
        end
        rd_n_prev = rd_n;
        if (done_req) begin
            cmp("busy_q_left", busy_q.size(), 0);
            cmp("rd_q_left", rd_q.size(), 0);
            $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
            $finish;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_conv(input logic [2:0] code, input int len);
        os     = code;
        convst = 1'b1;
        busy_q.push_back(len);
        tick();
        convst = 1'b0;
    endtask

    task automatic wait_busy_low();
        for (int i = 0; i < 20000; i++) begin
            if (busy == 1'b0) break;
            tick();
        end
        if (busy != 1'b0) begin
            $display("FAIL busy_timeout: busy still high, expected low");
            $fatal(1);
        end
        tick();
        tick();
    endtask

    task automatic do_read(input logic cs, input logic [15:0] exp_db, input logic exp_frst);
        cs_n = cs;
        rd_n = 1'b0;
        rd_q.push_back({exp_frst, exp_db});
        tick();
        tick();
        rd_n = 1'b1;
        tick();
    endtask

    task automatic end_reads();
        cs_n = 1'b1;
        tick();
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        chk_req++;
        tick();

        // Reads in IDLE with cs high leave the bus at zero.
        do_read(1'b1, 16'h0000, 1'b0);

        // First conversion, os=0.
        start_conv(3'd0, 200);
        wait_busy_low();
        for (int ch = 0; ch < 8; ch++) begin
            do_read(1'b0, 16'h0008 + 16'(ch), (ch == 0));
        end
        do_read(1'b0, 16'h0008, 1'b1);
        end_reads();

        // cs high read must not advance the pointer (ptr is 1 here).
        do_read(1'b1, 16'h0000, 1'b0);
        do_read(1'b0, 16'h0009, 1'b0);
        end_reads();

        // os=2, with os change, second CONVST and a read all during BUSY.
        start_conv(3'd2, 800);
        repeat (5) tick();
        os     = 3'd5;
        convst = 1'b1;
        tick();
        convst = 1'b0;
        repeat (3) tick();
        do_read(1'b0, 16'h0000, 1'b0);
        cs_n = 1'b1;
        wait_busy_low();
        do_read(1'b0, 16'h0010, 1'b1);
        do_read(1'b0, 16'h0011, 1'b0);
        end_reads();

        // os=7 behaves as os=0.
        start_conv(3'd7, 200);
        wait_busy_low();
        do_read(1'b0, 16'h0018, 1'b1);
        end_reads();

        // CONVST rise and RD fall together: conversion wins, read ignored.
        os     = 3'd0;
        cs_n   = 1'b0;
        rd_n   = 1'b0;
        convst = 1'b1;
        busy_q.push_back(200);
        rd_q.push_back({1'b0, 16'h0000});
        tick();
        convst = 1'b0;
        tick();
        rd_n = 1'b1;
        tick();
        cs_n = 1'b1;
        wait_busy_low();
        do_read(1'b0, 16'h0020, 1'b1);
        end_reads();

        // ADC RESET mid-conversion, with a CONVST edge during the reset.
        start_conv(3'd0, 50);
        repeat (49) tick();
        adc_reset = 1'b1;
        convst    = 1'b1;
        tick();
        adc_reset = 1'b0;
        tick();
        convst = 1'b0;
        tick();
        chk_req++;
        repeat (3) tick();

        // Counter restarted: next conversion gives channel 0 = 0x0008.
        start_conv(3'd0, 200);
        wait_busy_low();
        do_read(1'b0, 16'h0008, 1'b1);
        end_reads();

        repeat (5) tick();
        done_req = 1'b1;
        repeat (5) tick();
        $display("FAIL monitor: summary not reached, expected finish");
        $fatal(1);
    end

endmodule
